// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Provides the default widths, the requester IDs, the round-robin pointer type,
// the per-entry age stamp type and its saturating increment.
package reg_wb_arbiter_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 3;
  localparam int DEFAULT_NREG   = 8;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic {
    RR_A = REQ_A,
    RR_B = REQ_B
  } rr_t;

  typedef logic [1:0] age_t;

  localparam age_t AGE_MAX = 2'd3;

  // An entry never waits more than one cycle behind the other side, so a
  // saturating 2-bit count is enough to keep "older" unambiguous.
  function automatic age_t age_inc(input age_t a);
    return (a == AGE_MAX) ? a : age_t'(a + 2'd1);
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_wb_slot.sv
// wb_slot: one-entry writeback holding buffer.
// Ports:
//   CLK, RESET        clock, synchronous active-high reset (clears full/age)
//   accept            load in_addr/in_data this edge (takes priority over drain)
//   drain             entry is being written out this edge
//   in_addr, in_data  incoming request
//   full              entry holds a pending write
//   addr, data        buffered destination register and value
//   age               cycles waited since acceptance (saturating)
module wb_slot
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              accept,
  input  logic              drain,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output age_t              age
);

  // Control state: occupancy and age.  A refill on the same edge as a drain
  // keeps the slot full with the new entry and restarts its age.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      full <= 1'b0;
      age  <= '0;
    end else if (accept) begin
      full <= 1'b1;
      age  <= '0;
    end else if (drain) begin
      full <= 1'b0;
      age  <= '0;
    end else if (full) begin
      age  <= age_inc(age);
    end
  end

  // Payload only: qualified by full, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr <= in_addr;
      data <= in_data;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the register file's single write port between the
// ALU writeback (A) and the load writeback (B).  Each side is buffered in a
// wb_slot; the older buffered entry wins, same-edge arrivals alternate
// through rr_ptr.  An entry accepted at edge N is driven on the port after
// edge N+1 (one cycle later if the other side is older).
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   A_VALID/A_ADDR/A_DATA      ALU writeback request, A_READY handshake
//   B_VALID/B_ADDR/B_DATA      load writeback request, B_READY handshake
//   WRITE/INADDRESS/IN         registered register-file write port
//   PENDING                    per-register "write buffered or on the port"
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NREG   = DEFAULT_NREG
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              A_VALID,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_READY,
  input  logic              B_VALID,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_READY,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN,
  output logic [NREG-1:0]   PENDING
);

  logic              full_a, full_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] data_a, data_b;
  age_t              age_a, age_b;
  logic              grant_a, grant_b, tie;
  logic              accept_a, accept_b;
  rr_t               rr_ptr;

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
    .CLK     (CLK),
    .RESET   (RESET),
    .accept  (accept_a),
    .drain   (grant_a),
    .in_addr (A_ADDR),
    .in_data (A_DATA),
    .full    (full_a),
    .addr    (addr_a),
    .data    (data_a),
    .age     (age_a)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
    .CLK     (CLK),
    .RESET   (RESET),
    .accept  (accept_b),
    .drain   (grant_b),
    .in_addr (B_ADDR),
    .in_data (B_DATA),
    .full    (full_b),
    .addr    (addr_b),
    .data    (data_b),
    .age     (age_b)
  );

  // Oldest-first keeps same-register writes in acceptance order; only
  // same-edge arrivals (equal age) fall back to round-robin.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    tie     = 1'b0;
    if (!RESET) begin
      if (full_a && full_b) begin
        if (age_a > age_b) begin
          grant_a = 1'b1;
        end else if (age_b > age_a) begin
          grant_b = 1'b1;
        end else begin
          tie = 1'b1;
          if (rr_ptr == RR_A) grant_a = 1'b1;
          else                grant_b = 1'b1;
        end
      end else if (full_a) begin
        grant_a = 1'b1;
      end else if (full_b) begin
        grant_b = 1'b1;
      end
    end
  end

  // A draining slot can take a new entry on the same edge.
  assign A_READY  = !RESET && (!full_a || grant_a);
  assign B_READY  = !RESET && (!full_b || grant_b);
  assign accept_a = A_VALID && A_READY;
  assign accept_b = B_VALID && B_READY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_ptr <= RR_A;
    end else if (tie) begin
      rr_ptr <= (rr_ptr == RR_A) ? RR_B : RR_A;
    end
  end

  // Write-port register stage.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      WRITE     <= 1'b0;
      INADDRESS <= '0;
      IN        <= '0;
    end else if (grant_a) begin
      WRITE     <= 1'b1;
      INADDRESS <= addr_a;
      IN        <= data_a;
    end else if (grant_b) begin
      WRITE     <= 1'b1;
      INADDRESS <= addr_b;
      IN        <= data_b;
    end else begin
      WRITE     <= 1'b0;
    end
  end

  // Scoreboard decoded from registered state only, so hazard logic sees no
  // combinational path from the request inputs.
  always_comb begin
    PENDING = '0;
    for (int r = 0; r < NREG; r++) begin
      PENDING[r] = (full_a && (addr_a == ADDR_W'(r))) ||
                   (full_b && (addr_b == ADDR_W'(r))) ||
                   (WRITE  && (INADDRESS == ADDR_W'(r)));
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       A_VALID, B_VALID;
  logic [2:0] A_ADDR, B_ADDR;
  logic [7:0] A_DATA, B_DATA;
  logic       A_READY, B_READY;
  logic       WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
  logic [7:0] PENDING;

  int checks = 0;
  int failures = 0;

  // Register file model: commits whatever is on the write port at each edge.
  logic [7:0] regs [0:7];
  int wr_count = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (WRITE === 1'b1) begin
      regs[INADDRESS] <= IN;
      wr_count <= wr_count + 1;
    end
  end

  reg_wb_arbiter dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .A_VALID   (A_VALID),
    .A_ADDR    (A_ADDR),
    .A_DATA    (A_DATA),
    .A_READY   (A_READY),
    .B_VALID   (B_VALID),
    .B_ADDR    (B_ADDR),
    .B_DATA    (B_DATA),
    .B_READY   (B_READY),
    .WRITE     (WRITE),
    .INADDRESS (INADDRESS),
    .IN        (IN),
    .PENDING   (PENDING)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    A_VALID = 1'b1; A_ADDR = 3'd4; A_DATA = 8'h77;
    B_VALID = 1'b0; B_ADDR = 3'd0; B_DATA = 8'h00;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (WRITE !== 1'b0) begin failures++; $display("FAIL reset_write got=%b exp=0", WRITE); end
      checks++; if (INADDRESS !== 3'd0) begin failures++; $display("FAIL reset_inaddress got=%0d exp=0", INADDRESS); end
      checks++; if (IN !== 8'h00) begin failures++; $display("FAIL reset_in got=%h exp=00", IN); end
      checks++; if (A_READY !== 1'b0) begin failures++; $display("FAIL reset_a_ready got=%b exp=0", A_READY); end
      checks++; if (PENDING !== 8'h00) begin failures++; $display("FAIL reset_pending got=%h exp=00", PENDING); end
    end
    A_VALID = 1'b0;
    RESET = 1'b0;
    #1;
    checks++; if (A_READY !== 1'b1 || B_READY !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b%b exp=11", A_READY, B_READY); end
    step();
    checks++; if (wr_count !== 0) begin failures++; $display("FAIL reset_no_writes got=%0d exp=0", wr_count); end
  endtask

  task automatic test_single_a();
    A_VALID = 1'b1; A_ADDR = 3'd3; A_DATA = 8'h5A;
    #1;
    checks++; if (A_READY !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", A_READY); end
    step();
    A_VALID = 1'b0;
    checks++; if (WRITE !== 1'b0 || PENDING !== 8'h08) begin failures++; $display("FAIL single_buffered got=write %b pend %h exp=write 0 pend 08", WRITE, PENDING); end
    step();
    checks++; if (WRITE !== 1'b1 || INADDRESS !== 3'd3 || IN !== 8'h5A) begin failures++; $display("FAIL single_port got=%b/%0d/%h exp=1/3/5a", WRITE, INADDRESS, IN); end
    checks++; if (PENDING !== 8'h08) begin failures++; $display("FAIL single_pending_port got=%h exp=08", PENDING); end
    step();
    checks++; if (WRITE !== 1'b0 || PENDING !== 8'h00) begin failures++; $display("FAIL single_idle got=write %b pend %h exp=write 0 pend 00", WRITE, PENDING); end
    checks++; if (regs[3] !== 8'h5A) begin failures++; $display("FAIL single_reg3 got=%h exp=5a", regs[3]); end
  endtask

  task automatic test_tie();
    for (int rep = 0; rep < 2; rep++) begin
      A_VALID = 1'b1; A_ADDR = 3'd1; A_DATA = 8'h11;
      B_VALID = 1'b1; B_ADDR = 3'd2; B_DATA = 8'h22;
      step();
      A_VALID = 1'b0; B_VALID = 1'b0;
      checks++; if (PENDING !== 8'h06) begin failures++; $display("FAIL tie%0d_pending got=%h exp=06", rep, PENDING); end
      step();
      checks++;
      if (WRITE !== 1'b1 || INADDRESS !== ((rep == 0) ? 3'd1 : 3'd2) || IN !== ((rep == 0) ? 8'h11 : 8'h22)) begin
        failures++; $display("FAIL tie%0d_first got=%b/%0d/%h exp=first=%s", rep, WRITE, INADDRESS, IN, (rep == 0) ? "A" : "B");
      end
      step();
      checks++;
      if (WRITE !== 1'b1 || INADDRESS !== ((rep == 0) ? 3'd2 : 3'd1) || IN !== ((rep == 0) ? 8'h22 : 8'h11)) begin
        failures++; $display("FAIL tie%0d_second got=%b/%0d/%h exp=second=%s", rep, WRITE, INADDRESS, IN, (rep == 0) ? "B" : "A");
      end
      step();
      checks++; if (WRITE !== 1'b0) begin failures++; $display("FAIL tie%0d_idle got=%b exp=0", rep, WRITE); end
    end
  endtask

  task automatic test_ordering();
    B_VALID = 1'b1; B_ADDR = 3'd5; B_DATA = 8'hAA;
    step();
    B_VALID = 1'b0;
    A_VALID = 1'b1; A_ADDR = 3'd5; A_DATA = 8'hBB;
    checks++; if (A_READY !== 1'b1) begin failures++; $display("FAIL order_a_ready got=%b exp=1", A_READY); end
    step();
    A_VALID = 1'b0;
    checks++; if (WRITE !== 1'b1 || INADDRESS !== 3'd5 || IN !== 8'hAA) begin failures++; $display("FAIL order_first got=%b/%0d/%h exp=1/5/aa", WRITE, INADDRESS, IN); end
    step();
    checks++; if (WRITE !== 1'b1 || INADDRESS !== 3'd5 || IN !== 8'hBB) begin failures++; $display("FAIL order_second got=%b/%0d/%h exp=1/5/bb", WRITE, INADDRESS, IN); end
    step();
    checks++; if (regs[5] !== 8'hBB || WRITE !== 1'b0) begin failures++; $display("FAIL order_reg5 got=%h write %b exp=bb write 0", regs[5], WRITE); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      A_VALID = 1'b1; A_ADDR = 3'(i); A_DATA = 8'(i + 1);
      #1;
      checks++; if (A_READY !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i, A_READY); end
      step();
      if (i > 0) begin
        checks++;
        if (WRITE !== 1'b1 || INADDRESS !== 3'(i - 1) || IN !== 8'(i)) begin
          failures++; $display("FAIL b2b_port%0d got=%b/%0d/%h exp=1/%0d/%h", i, WRITE, INADDRESS, IN, i - 1, i);
        end
      end
    end
    A_VALID = 1'b0;
    step();
    checks++; if (WRITE !== 1'b1 || INADDRESS !== 3'd7 || IN !== 8'h08) begin failures++; $display("FAIL b2b_last got=%b/%0d/%h exp=1/7/08", WRITE, INADDRESS, IN); end
    step();
    for (int r = 0; r < 8; r++) begin
      checks++; if (regs[r] !== 8'(r + 1)) begin failures++; $display("FAIL b2b_reg%0d got=%h exp=%h", r, regs[r], r + 1); end
    end
  endtask

  task automatic test_reset_mid();
    A_VALID = 1'b1; A_ADDR = 3'd6; A_DATA = 8'hE6;
    B_VALID = 1'b1; B_ADDR = 3'd7; B_DATA = 8'hE7;
    step();
    A_VALID = 1'b0; B_VALID = 1'b0;
    checks++; if (PENDING !== 8'hC0) begin failures++; $display("FAIL rmid_pending_full got=%h exp=c0", PENDING); end
    RESET = 1'b1;
    #1;
    checks++; if (A_READY !== 1'b0 || B_READY !== 1'b0) begin failures++; $display("FAIL rmid_ready got=%b%b exp=00", A_READY, B_READY); end
    step();
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (WRITE !== 1'b0 || PENDING !== 8'h00) begin failures++; $display("FAIL rmid_idle%0d got=write %b pend %h exp=write 0 pend 00", i, WRITE, PENDING); end
      step();
    end
    checks++; if (regs[6] !== 8'h07 || regs[7] !== 8'h08) begin failures++; $display("FAIL rmid_stale got=%h/%h exp=07/08", regs[6], regs[7]); end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_tie();
    test_ordering();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
